// File: rtl/soc2_ack_in_pio_if.sv
// Avalon-MM slave bus bundle for the ACK input PIO: register access plus interrupt.
interface soc2_ack_in_pio_if;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/soc2_ack_in_pio.sv
// ACK input PIO: synchronises external ACK lines, captures edges sticky-wise and
// raises a maskable level interrupt; closes the REQ/ACK handshake in software.
module soc2_ack_in_pio #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  soc2_ack_in_pio_if.slave bus
);
  localparam int unsigned SETTLE_MAX = SYNC_STAGES + 1;
  localparam int unsigned CNT_W      = $clog2(SETTLE_MAX + 1);
  localparam int unsigned DATA_W     = 32;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]  prev_q;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  cap_q, cap_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              irq_q, irq_d;

  logic [WIDTH-1:0]  sync_in_c;
  logic [WIDTH-1:0]  rise_c, fall_c, edge_c, clr_c, wdata_c;
  logic              settled_c, wr_c;
  logic              unused_c;

  // Only the low WIDTH bits of writedata reach any register.
  assign unused_c = ^{bus.writedata, 1'b0};

  // Next-state logic for synchroniser, settle guard, capture, mask, irq and read mux.
  always_comb begin
    sync_in_c  = sync_q[SYNC_STAGES-1];
    sync_d     = {sync_q[SYNC_STAGES-2:0], in_port};
    wr_c       = bus.chipselect & ~bus.write_n;
    wdata_c    = bus.writedata[WIDTH-1:0];
    settled_c  = (settle_q == CNT_W'(SETTLE_MAX));
    settle_d   = settled_c ? settle_q : settle_q + CNT_W'(1);
    rise_c     = sync_in_c & ~prev_q;
    fall_c     = ~sync_in_c & prev_q;
    edge_c     = '0;
    clr_c      = '0;
    mask_d     = mask_q;
    readdata_d = '0;

    // Edges are ignored until the synchroniser has flushed post-reset contents.
    if (settled_c) begin
      if (EDGE_TYPE == 0)      edge_c = rise_c;
      else if (EDGE_TYPE == 1) edge_c = fall_c;
      else                     edge_c = rise_c | fall_c;
    end

    if (wr_c && (bus.address == ADDR_EDGECAP)) clr_c  = wdata_c;
    if (wr_c && (bus.address == ADDR_IRQMASK)) mask_d = wdata_c;

    // A fresh edge wins over a simultaneous clear so no edge is lost.
    cap_d = edge_c | (cap_q & ~clr_c);
    irq_d = |(cap_q & mask_q);

    case (bus.address)
      ADDR_DATA:    readdata_d = DATA_W'(sync_in_c);
      ADDR_IRQMASK: readdata_d = DATA_W'(mask_q);
      ADDR_EDGECAP: readdata_d = DATA_W'(cap_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      prev_q     <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      settle_q   <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= sync_in_c;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      settle_q   <= settle_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;
endmodule

// File: tb/tb_soc2_ack_in_pio.sv
// Bench for the ACK input PIO: a default 1-bit rising-edge instance and a
// 4-bit any-edge instance, checked against a queue of expected reads.
module tb_soc2_ack_in_pio;
  logic       clk;
  logic       reset_n;
  logic [0:0] in0;
  logic [3:0] in1;

  soc2_ack_in_pio_if b0 ();
  soc2_ack_in_pio_if b1 ();

  soc2_ack_in_pio u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in0),
    .bus     (b0)
  );

  soc2_ack_in_pio #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in1),
    .bus     (b1)
  );

  typedef struct {
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd0(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    b0.address = a; b0.chipselect = 1'b1; b0.write_n = 1'b1;
    step();
    d = b0.readdata;
    b0.chipselect = 1'b0;
  endtask

  task automatic rd1(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    b1.address = a; b1.chipselect = 1'b1; b1.write_n = 1'b1;
    step();
    d = b1.readdata;
    b1.chipselect = 1'b0;
  endtask

  task automatic wr0(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    b0.address = a; b0.chipselect = 1'b1; b0.write_n = 1'b0; b0.writedata = d;
    @(negedge clk);
    b0.chipselect = 1'b0; b0.write_n = 1'b1; b0.writedata = '0;
  endtask

  task automatic wr1(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    b1.address = a; b1.chipselect = 1'b1; b1.write_n = 1'b0; b1.writedata = d;
    @(negedge clk);
    b1.chipselect = 1'b0; b1.write_n = 1'b1; b1.writedata = '0;
  endtask

  task automatic test_reset();
    logic [1:0]  addrs [3];
    logic [31:0] d;
    exp_t        e;
    addrs = '{2'd3, 2'd0, 2'd2};
    reset_n = 1'b0; in0 = 1'b1; in1 = 4'h0;
    b0.address = '0; b0.chipselect = 1'b0; b0.write_n = 1'b1; b0.writedata = '0;
    b1.address = '0; b1.chipselect = 1'b0; b1.write_n = 1'b1; b1.writedata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    sb.push_back('{32'h0, 1'b0});
    sb.push_back('{32'h1, 1'b0});
    sb.push_back('{32'h0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      rd0(addrs[i], d);
      e = sb.pop_front();
      checks++;
      if (d !== e.data) begin
        failures++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", addrs[i], d, e.data);
      end
      checks++;
      if (b0.irq !== e.irq) begin
        failures++;
        $display("FAIL reset_irq got=%b exp=%b", b0.irq, e.irq);
      end
    end
    sb.push_back('{32'h0, 1'b0});
    rd1(2'd3, d);
    e = sb.pop_front();
    checks++;
    if (d !== e.data || b1.irq !== e.irq) begin
      failures++;
      $display("FAIL reset_dut1 got=%h/%b exp=%h/%b", d, b1.irq, e.data, e.irq);
    end
  endtask

  task automatic test_rise();
    logic [31:0] d;
    exp_t        e;
    @(negedge clk);
    in0 = 1'b0;
    repeat (5) @(negedge clk);
    sb.push_back('{32'h0, 1'b0});
    rd0(2'd3, d);
    e = sb.pop_front();
    checks++;
    if (d !== e.data) begin
      failures++;
      $display("FAIL rise_fall_ignored got=%h exp=%h", d, e.data);
    end
    wr0(2'd2, 32'h1);
    b0.address = 2'd3; b0.chipselect = 1'b1; b0.write_n = 1'b1;
    in0 = 1'b1;
    sb.push_back('{32'h0, 1'b0});
    sb.push_back('{32'h0, 1'b0});
    sb.push_back('{32'h0, 1'b0});
    sb.push_back('{32'h1, 1'b1});
    sb.push_back('{32'h1, 1'b1});
    for (int i = 1; i <= 5; i++) begin
      step();
      e = sb.pop_front();
      checks++;
      if (b0.readdata !== e.data) begin
        failures++;
        $display("FAIL rise_latency cyc=T+%0d readdata got=%h exp=%h", i, b0.readdata, e.data);
      end
      checks++;
      if (b0.irq !== e.irq) begin
        failures++;
        $display("FAIL rise_latency cyc=T+%0d irq got=%b exp=%b", i, b0.irq, e.irq);
      end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    sb.push_back('{32'h1, 1'b1});
    sb.push_back('{32'h0, 1'b0});
    sb.push_back('{32'h0, 1'b0});
    @(negedge clk);
    b0.address = 2'd3; b0.chipselect = 1'b1; b0.write_n = 1'b0; b0.writedata = 32'h1;
    for (int i = 0; i < 3; i++) begin
      step();
      e = sb.pop_front();
      checks++;
      if (b0.readdata !== e.data || b0.irq !== e.irq) begin
        failures++;
        $display("FAIL clear cyc=%0d got=%h/%b exp=%h/%b", i, b0.readdata, b0.irq, e.data, e.irq);
      end
      @(negedge clk);
      b0.write_n = 1'b1; b0.writedata = '0;
    end
  endtask

  task automatic test_collision();
    exp_t e;
    @(negedge clk);
    b0.address = 2'd3; b0.chipselect = 1'b1; b0.write_n = 1'b1;
    in0 = 1'b0;
    repeat (5) @(negedge clk);
    in0 = 1'b1;
    repeat (5) @(negedge clk);
    sb.push_back('{32'h1, 1'b1});
    step();
    e = sb.pop_front();
    checks++;
    if (b0.readdata !== e.data || b0.irq !== e.irq) begin
      failures++;
      $display("FAIL collision_pre got=%h/%b exp=%h/%b", b0.readdata, b0.irq, e.data, e.irq);
    end
    @(negedge clk);
    in0 = 1'b0;
    repeat (5) @(negedge clk);
    in0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    b0.write_n = 1'b0; b0.writedata = 32'h1;
    sb.push_back('{32'h1, 1'b1});
    sb.push_back('{32'h1, 1'b1});
    sb.push_back('{32'h1, 1'b1});
    for (int i = 0; i < 3; i++) begin
      step();
      e = sb.pop_front();
      checks++;
      if (b0.readdata !== e.data || b0.irq !== e.irq) begin
        failures++;
        $display("FAIL collision cyc=%0d got=%h/%b exp=%h/%b", i, b0.readdata, b0.irq, e.data, e.irq);
      end
      @(negedge clk);
      b0.write_n = 1'b1; b0.writedata = '0;
    end
  endtask

  task automatic test_multibit();
    logic [1:0]  addrs [5];
    logic [31:0] d;
    exp_t        e;
    wr1(2'd2, 32'h4);
    in1 = 4'b0101;
    repeat (6) @(negedge clk);
    sb.push_back('{32'h5, 1'b1});
    rd1(2'd3, d);
    e = sb.pop_front();
    checks++;
    if (d !== e.data || b1.irq !== e.irq) begin
      failures++;
      $display("FAIL multi_capture got=%h/%b exp=%h/%b", d, b1.irq, e.data, e.irq);
    end
    wr1(2'd3, 32'h4);
    wr1(2'd0, 32'hFFFF_FFFF);
    wr1(2'd1, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    addrs = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
    sb.push_back('{32'h1, 1'b0});
    sb.push_back('{32'h4, 1'b0});
    sb.push_back('{32'h5, 1'b0});
    sb.push_back('{32'h0, 1'b0});
    sb.push_back('{32'h1, 1'b0});
    for (int i = 0; i < 5; i++) begin
      rd1(addrs[i], d);
      e = sb.pop_front();
      checks++;
      if (d !== e.data || b1.irq !== e.irq) begin
        failures++;
        $display("FAIL multi_regs addr=%0d got=%h/%b exp=%h/%b", addrs[i], d, b1.irq, e.data, e.irq);
      end
    end
    @(negedge clk);
    in1 = 4'b0000;
    repeat (6) @(negedge clk);
    sb.push_back('{32'h5, 1'b1});
    rd1(2'd3, d);
    e = sb.pop_front();
    checks++;
    if (d !== e.data || b1.irq !== e.irq) begin
      failures++;
      $display("FAIL multi_fall got=%h/%b exp=%h/%b", d, b1.irq, e.data, e.irq);
    end
  endtask

  task automatic test_midreset();
    logic [1:0]  addrs [3];
    logic [31:0] d;
    exp_t        e;
    @(negedge clk);
    b0.address = 2'd3; b0.chipselect = 1'b0; b0.write_n = 1'b1;
    checks++;
    if (b0.irq !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre irq got=%b exp=1", b0.irq);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (b0.irq !== 1'b0 || b0.readdata !== 32'h0) begin
      failures++;
      $display("FAIL midreset_async got=%h/%b exp=00000000/0", b0.readdata, b0.irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    addrs = '{2'd3, 2'd2, 2'd0};
    sb.push_back('{32'h0, 1'b0});
    sb.push_back('{32'h0, 1'b0});
    sb.push_back('{32'h1, 1'b0});
    for (int i = 0; i < 3; i++) begin
      rd0(addrs[i], d);
      e = sb.pop_front();
      checks++;
      if (d !== e.data || b0.irq !== e.irq) begin
        failures++;
        $display("FAIL midreset_read addr=%0d got=%h/%b exp=%h/%b", addrs[i], d, b0.irq, e.data, e.irq);
      end
    end
    sb.push_back('{32'h0, 1'b0});
    rd1(2'd3, d);
    e = sb.pop_front();
    checks++;
    if (d !== e.data || b1.irq !== e.irq) begin
      failures++;
      $display("FAIL midreset_dut1 got=%h/%b exp=%h/%b", d, b1.irq, e.data, e.irq);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_clear();
    test_collision();
    test_multibit();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/soc2_ack_in_pio.md
Name: soc2_ack_in_pio

Overview:
- Avalon-MM slave input port. Receives the external ACK line(s) that answer the SoC's REQ output port.
- Synchronises the asynchronous input into clk and detects edges.
- Latches detected edges in a sticky edge-capture register and raises a maskable level interrupt to the processor.
- Sits beside the REQ output PIO on the same Avalon interconnect; together they close the REQ/ACK handshake in software.

Parameters:
- WIDTH, 1, number of input bits (1..32).
- EDGE_TYPE, 0, edge that sets capture: 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2, flip-flops in the input synchroniser (2..4).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  external ACK input, asynchronous to clk.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt request to CPU.

Behaviour:
- Clocking and reset: all state is clocked on posedge clk and cleared asynchronously while reset_n=0.
- Reset values: readdata=0, irq=0, irq_mask=0, edge_capture=0, synchroniser=0, prev=0, settle counter=0.
- Synchroniser: in_port passes through SYNC_STAGES flops to give sync_in. prev holds sync_in delayed by one cycle.
- Edge detect: rise = sync_in & ~prev; fall = ~sync_in & prev; edge is selected by EDGE_TYPE.
- Settle guard after reset:
  - A counter runs from 0 to SYNC_STAGES+1 and then saturates.
  - Edge detect is gated off until the counter saturates.
  - This stops an input held high through reset from producing a spurious capture.
- Register map (write = chipselect & ~write_n):
  - addr 0 DATA: read returns zero-extended sync_in. Writes are ignored.
  - addr 1: reserved. Reads 0, writes ignored.
  - addr 2 IRQMASK: read/write, bits [WIDTH-1:0]. Upper bits read 0.
  - addr 3 EDGECAP: read returns captured edges. Writing 1 to a bit clears that bit; writing 0 has no effect.
- Edge capture per bit: next = edge | (cap & ~(wr_addr3 & writedata)).
  - A new edge in the same cycle as a clear write to that bit leaves the bit set, so no edge is lost.
  - Bits stay set until software clears them; further edges have no extra effect.
- Read path:
  - readdata <= read mux of address every clk. There is no read strobe; the value is gated by address only.
  - Read latency is 1 cycle: data for the address presented in cycle N appears in cycle N+1.
  - Unused bits are 0.
- irq: registered, irq <= |(edge_capture & irq_mask). It asserts 1 cycle after the capture bit or mask bit becomes 1 and stays asserted while the condition holds.
- Input-to-capture latency: an in_port transition is visible in edge_capture SYNC_STAGES+1 cycles later and in irq 1 cycle after that.
- Pulses on in_port shorter than one clk period may be missed; this is allowed and is not an error.
- Reset mid-operation: all state clears immediately, irq drops asynchronously, and the settle guard restarts.

Test Plan:
- Reset with in_port=1 held: after reset release, wait 10 cycles -> EDGECAP reads 0, irq=0, DATA reads 0x1.
- Rising edge, defaults (WIDTH=1, EDGE_TYPE=0, SYNC_STAGES=2):
  - Write IRQMASK=1, then drive in_port 0->1 at cycle T.
  - Expect EDGECAP bit0=1 at T+3 and irq=1 at T+4.
  - Reading addr 3 returns 0x00000001 one cycle after the address is presented.
- Clear: write EDGECAP=0x1 -> the capture bit clears the next cycle, irq deasserts one cycle later, and reads return 0.
- Clear collision: set the write EDGECAP=0x1 in the same cycle a new rising edge is detected -> EDGECAP stays 1 and irq stays 1.
- Mask and multi-bit (WIDTH=4, EDGE_TYPE=2):
  - Toggle bits 0 and 2 with IRQMASK=0x4 -> EDGECAP=0x5 and irq=1.
  - Write EDGECAP=0x4 -> EDGECAP=0x1 and irq=0.
  - Writes to addr 0 and addr 1 leave all registers unchanged.
- Reset mid-operation: with EDGECAP=0x1 and irq=1, pulse reset_n low for 1 cycle -> irq drops immediately and all registers read 0 afterwards.
